cnet_reg_target: RTL and testbench

- CNET-side register target on the CPCI↔CNET register bus, running in the CNET clock domain.
- Accepts write and read requests issued by the CPCI-side register interface.
- Completes writes with a one-cycle `cpci_wr_rdy` pulse.
- Answers reads with a deterministic data pattern (the zero-extended request address) and a one-cycle `cpci_rd_rdy` pulse.
- Used as the bus responder when bringing up and verifying the CPCI register interface, including read-timeout paths.

---
 rtl/cnet_reg_target.sv | 146 ++++++++++++++
 tb/tb_cnet_reg_target.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnet_reg_target.sv
// CNET-side register target for the CPCI<->CNET register bus.
// Writes complete with a one-cycle cpci_wr_rdy pulse after WR_LATENCY cycles.
// Reads return the zero-extended request address with a one-cycle cpci_rd_rdy
// pulse after RD_LATENCY cycles. DATA_WIDTH must be >= ADDR_WIDTH,
// WR_LATENCY >= 1 and RD_LATENCY >= 2.
module cnet_reg_target #(
    parameter int unsigned ADDR_WIDTH = 27,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WR_LATENCY = 2,
    parameter int unsigned RD_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpci_req,
    input  logic                  cpci_rd_wr_L,
    input  logic [ADDR_WIDTH-1:0] cpci_addr,
    inout  wire  [DATA_WIDTH-1:0] cpci_data,
    output logic                  cpci_wr_rdy,
    output logic                  cpci_rd_rdy
);

    localparam int unsigned MAX_LAT = (WR_LATENCY > RD_LATENCY) ? WR_LATENCY : RD_LATENCY;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StWrWait,
        StRdWait,
        StRdDrive
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   w_addr_nxt;
    logic                    r_wr_rdy;
    logic                    w_wr_rdy_nxt;
    logic                    r_rd_rdy;
    logic                    w_rd_rdy_nxt;
    logic                    r_oe;
    logic                    w_oe_nxt;
    logic [DATA_WIDTH-1:0]   w_rd_data;

    // State, counter, latched address and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wr_rdy <= 1'b0;
            r_rd_rdy <= 1'b0;
            r_oe     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_addr   <= w_addr_nxt;
            r_wr_rdy <= w_wr_rdy_nxt;
            r_rd_rdy <= w_rd_rdy_nxt;
            r_oe     <= w_oe_nxt;
        end
    end

    // Next-state: r_cnt holds the cycles left until the rdy cycle, which is
    // the last cycle of an operation; requests are only accepted from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        unique case (r_state)
            StIdle: begin
                if (cpci_req) begin
                    w_addr_nxt = cpci_addr;
                    if (cpci_rd_wr_L) begin
                        w_state_nxt = StRdWait;
                        w_cnt_nxt   = CNT_W'(RD_LATENCY - 1);
                    end else begin
                        w_state_nxt = StWrWait;
                        w_cnt_nxt   = CNT_W'(WR_LATENCY - 1);
                    end
                end
            end
            StWrWait: begin
                if (r_cnt == '0) begin
                    // wr_rdy cycle: the held request is not re-accepted here
                    w_state_nxt = StIdle;
                end else if (!cpci_req) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            StRdWait: begin
                if (!cpci_req) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = StRdDrive;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            StRdDrive: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output next values: rdy and bus enable are registered, so they are
    // decoded one cycle ahead of the cycle in which they appear.
    always_comb begin
        w_wr_rdy_nxt = 1'b0;
        w_rd_rdy_nxt = 1'b0;
        w_oe_nxt     = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_wr_rdy_nxt = cpci_req && !cpci_rd_wr_L && (WR_LATENCY == 1);
                w_oe_nxt     = cpci_req && cpci_rd_wr_L && (RD_LATENCY == 2);
            end
            StWrWait: begin
                w_wr_rdy_nxt = cpci_req && (r_cnt == CNT_W'(1));
            end
            StRdWait: begin
                w_rd_rdy_nxt = cpci_req && (r_cnt == CNT_W'(1));
                w_oe_nxt     = cpci_req && ((r_cnt == CNT_W'(1)) || (r_cnt == CNT_W'(2)));
            end
            default: begin
                w_oe_nxt     = 1'b0;
            end
        endcase
    end

    // Read data is the latched address, zero-extended
    assign w_rd_data   = DATA_WIDTH'(r_addr);
    assign cpci_data   = r_oe ? w_rd_data : {DATA_WIDTH{1'bz}};
    assign cpci_wr_rdy = r_wr_rdy;
    assign cpci_rd_rdy = r_rd_rdy;

endmodule

// File: tb/tb_cnet_reg_target.sv
// Randomised scoreboard bench for cnet_reg_target.
module tb_cnet_reg_target;

    localparam int unsigned AW = 27;
    localparam int unsigned DW = 32;
    localparam int unsigned WL = 2;
    localparam int unsigned RL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          rd_wr_L;
    logic [AW-1:0] addr;
    wire  [DW-1:0] cpci_data;
    logic          tb_oe;
    logic [DW-1:0] tb_wdata;
    logic          wr_rdy;
    logic          rd_rdy;

    assign cpci_data = tb_oe ? tb_wdata : {DW{1'bz}};

    cnet_reg_target #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WR_LATENCY (WL),
        .RD_LATENCY (RL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpci_req     (req),
        .cpci_rd_wr_L (rd_wr_L),
        .cpci_addr    (addr),
        .cpci_data    (cpci_data),
        .cpci_wr_rdy  (wr_rdy),
        .cpci_rd_rdy  (rd_rdy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            is_rd;
        logic [AW-1:0] addr;
        int unsigned   exp_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   held     = 1'b0;
    bit   prev_rd  = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void check_released(string name, logic [DW-1:0] v);
        n_checks++;
        if (!((v === {DW{1'bz}}) || (v === '0))) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected high-Z (cycle %0d)", name, v, cyc);
        end
    endfunction

    // Monitor: pops the expected response whenever a rdy pulse appears and
    // checks who owns the data bus every cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   drive;
        if (!reset) begin
            if (sb.size() > 0 && sb[0].exp_cyc < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL rdy_missing: got no pulse expected one at cycle %0d", sb[0].exp_cyc);
                void'(sb.pop_front());
            end
            check("rdy_exclusive", 64'(wr_rdy & rd_rdy), 64'(0));
            if (wr_rdy || rd_rdy) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rdy_unexpected: got wr=%0b rd=%0b expected none (cycle %0d)",
                             wr_rdy, rd_rdy, cyc);
                end else begin
                    e = sb.pop_front();
                    check("rdy_type", 64'(rd_rdy), 64'(e.is_rd));
                    check("rdy_latency", 64'(cyc), 64'(e.exp_cyc));
                    if (rd_rdy) check("rd_data", 64'(cpci_data), 64'(DW'(e.addr)));
                end
            end
            drive = (sb.size() > 0) && sb[0].is_rd && (cyc + 1 == sb[0].exp_cyc);
            if (drive) begin
                check("bus_early_drive", 64'(cpci_data), 64'(DW'(sb[0].addr)));
            end else if (!rd_rdy) begin
                if (tb_oe) check("bus_wr_data", 64'(cpci_data), 64'(tb_wdata));
                else check_released("bus_released", cpci_data);
            end
        end
    end

    // Issue one request (called #1 after a rising edge) and wait for its rdy.
    task automatic issue(input bit is_rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit hold_after, input int unsigned gap);
        bit seen;
        int unsigned lat;
        lat      = is_rd ? RL : WL;
        req      = 1'b1;
        rd_wr_L  = is_rd;
        addr     = a;
        tb_wdata = d;
        // After a read rdy cycle the bus still belongs to the target
        tb_oe    = !is_rd && !(held && prev_rd);
        sb.push_back('{is_rd, a, cyc + lat + (held ? 1 : 0)});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (!is_rd) tb_oe = 1'b1;
            seen = is_rd ? rd_rdy : wr_rdy;
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL rdy_timeout: got no pulse expected one for addr 0x%0h", a);
            sb.delete();
        end
        prev_rd = is_rd;
        if (hold_after && seen) begin
            held = 1'b1;
        end else begin
            held  = 1'b0;
            req   = 1'b0;
            tb_oe = 1'b0;
            repeat (gap + 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        req      = 1'b0;
        rd_wr_L  = 1'b0;
        addr     = '0;
        tb_oe    = 1'b0;
        tb_wdata = '0;
        #1;
        check("reset_wr_rdy", 64'(wr_rdy), 64'(0));
        check("reset_rd_rdy", 64'(rd_rdy), 64'(0));
        check_released("reset_bus", cpci_data);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_wr_rdy", 64'(wr_rdy), 64'(0));
        check("idle_rd_rdy", 64'(rd_rdy), 64'(0));

        // Directed write, read, read->write held back-to-back
        issue(1'b0, 27'h0123456, 32'hDEADBEEF, 1'b0, 0);
        issue(1'b1, 27'h7FFFFFF, 32'h0, 1'b0, 1);
        issue(1'b1, 27'h0000010, 32'h0, 1'b1, 0);
        issue(1'b0, 27'h0000020, 32'h55AA55AA, 1'b0, 2);

        // Reset while the read is about to be presented
        req     = 1'b1;
        rd_wr_L = 1'b1;
        addr    = 27'h1234567;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("rst_pre_drive", 64'(cpci_data), 64'(32'h01234567));
        reset = 1'b1;
        #1;
        check("rst_async_wr_rdy", 64'(wr_rdy), 64'(0));
        check("rst_async_rd_rdy", 64'(rd_rdy), 64'(0));
        check_released("rst_async_bus", cpci_data);
        req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        issue(1'b1, 27'h0ABCDEF, 32'h0, 1'b0, 0);

        // Withdraw a write during WR_WAIT: no pulse expected
        req      = 1'b1;
        rd_wr_L  = 1'b0;
        addr     = 27'h0000044;
        tb_wdata = 32'h13572468;
        tb_oe    = 1'b1;
        @(posedge clk);
        #1;
        req   = 1'b0;
        tb_oe = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        issue(1'b0, 27'h0000048, 32'hCAFEF00D, 1'b0, 0);

        // Random traffic
        for (int i = 0; i < 50; i++) begin
            issue(1'($urandom % 2), AW'($urandom), $urandom,
                  (i != 49) && ($urandom % 3 == 0), $urandom % 4);
        end

        repeat (10) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected one before time 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
